// File: rtl/direct_map_cache_if.sv
// Bus bundle between the instruction-cache refill FSM (master) and the
// direct-mapped storage array (slave): one combinational lookup port and
// one refill write port.
interface direct_map_cache_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  hit;
   logic [DATA_WIDTH-1:0] data;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  write_valid;

   modport master (
      output req_addr,
      output write_addr,
      output write_data,
      output write_valid,
      input  hit,
      input  data
   );

   modport slave (
      input  req_addr,
      input  write_addr,
      input  write_data,
      input  write_valid,
      output hit,
      output data
   );
endinterface

// File: rtl/direct_map_cache.sv
// Direct-mapped, one-word-per-line instruction cache storage.
// Lookup is purely combinational so the parent FSM can sample hit/data on
// the same edge it moves the address. Refill writes land on the rising edge.
// Only the valid bits are reset; tag and data arrays power up undefined.
module direct_map_cache #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 8
) (
   input logic                 clk,
   input logic                 reset,
   direct_map_cache_if.slave   bus
);
   localparam int LINES     = 1 << INDEX_WIDTH;
   localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;

   logic [LINES-1:0]      valid_r;
   logic [TAG_WIDTH-1:0]  tag_r  [LINES];
   logic [DATA_WIDTH-1:0] data_r [LINES];

   logic [INDEX_WIDTH-1:0] req_idx_s;
   logic [TAG_WIDTH-1:0]   req_tag_s;
   logic [INDEX_WIDTH-1:0] wr_idx_s;
   logic [TAG_WIDTH-1:0]   wr_tag_s;
   logic                   hit_s;
   logic [DATA_WIDTH-1:0]  data_s;

   // Byte-offset bits are ignored: all fetches are word aligned.
   logic unused_offset_s;

   assign req_idx_s       = bus.req_addr[INDEX_WIDTH+1:2];
   assign req_tag_s       = bus.req_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
   assign wr_idx_s        = bus.write_addr[INDEX_WIDTH+1:2];
   assign wr_tag_s        = bus.write_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
   assign unused_offset_s = ^{bus.req_addr[1:0], bus.write_addr[1:0]};

   // Valid bits: reset clears every line and wins over a simultaneous refill.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r <= '0;
      end else if (bus.write_valid) begin
         valid_r[wr_idx_s] <= 1'b1;
      end
   end

   // Tag/data arrays: overwrite the indexed line on refill; never reset.
   always_ff @(posedge clk) begin
      if (!reset && bus.write_valid) begin
         tag_r[wr_idx_s]  <= wr_tag_s;
         data_r[wr_idx_s] <= bus.write_data;
      end
   end

   // Combinational lookup: hit on valid + tag match, data forced to zero on miss.
   always_comb begin
      hit_s  = 1'b0;
      data_s = '0;
      if (valid_r[req_idx_s] && (tag_r[req_idx_s] == req_tag_s)) begin
         hit_s  = 1'b1;
         data_s = data_r[req_idx_s];
      end else begin
         hit_s  = 1'b0;
         data_s = '0;
      end
   end

   assign bus.hit  = hit_s;
   assign bus.data = data_s;
endmodule

// File: tb/tb_direct_map_cache.sv
// Self-checking bench for direct_map_cache: directed scenarios followed by
// randomized refills, lookups and occasional resets, all checked against a
// per-line reference model built from address arithmetic.
module tb_direct_map_cache;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int IW    = 8;
   localparam int LINES = 256;

   logic clk;
   logic reset;

   direct_map_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   direct_map_cache #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int vectors;
   int miscompares;

   // Reference model: per line a valid flag, the stored tag and the word.
   bit          m_valid [LINES];
   int unsigned m_tag   [LINES];
   logic [31:0] m_data  [LINES];
   logic [31:0] written_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model update on the same edge the DUT captures writes/reset.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < LINES; i++) m_valid[i] <= 1'b0;
      end else if (bus.write_valid) begin
         m_valid[(bus.write_addr / 4) % LINES] <= 1'b1;
         m_tag[(bus.write_addr / 4) % LINES]   <= bus.write_addr / 1024;
         m_data[(bus.write_addr / 4) % LINES]  <= bus.write_data;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void ref_lookup(input logic [31:0] a, output logic h, output logic [31:0] d);
      int unsigned i;
      i = (a / 4) % LINES;
      h = m_valid[i] && (m_tag[i] == a / 1024);
      d = h ? m_data[i] : 32'h0;
   endfunction

   // Check the current combinational lookup for whatever req_addr holds.
   task automatic check_now(input string tag);
      logic        eh;
      logic [31:0] ed;
      ref_lookup(bus.req_addr, eh, ed);
      check_eq({tag, "_hit"}, {31'd0, bus.hit}, {31'd0, eh});
      check_eq({tag, "_data"}, bus.data, ed);
   endtask

   task automatic lookup(input string tag, input logic [31:0] a);
      @(negedge clk);
      bus.req_addr = a;
      #1;
      check_now(tag);
   endtask

   task automatic write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.write_addr  = a;
      bus.write_data  = d;
      bus.write_valid = 1'b1;
      written_q.push_back(a);
      @(negedge clk);
      bus.write_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      vectors     = 0;
      miscompares = 0;
      reset           = 1'b1;
      bus.req_addr    = 32'h0;
      bus.write_addr  = 32'h0;
      bus.write_data  = 32'h0;
      bus.write_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Empty cache misses everywhere.
      for (int i = 0; i < LINES; i++) begin
         lookup("sweep", 32'(i * 4));
         check_eq("sweep_hit0", {31'd0, bus.hit}, 32'd0);
      end

      // Basic write/read and same-index different-tag miss.
      write(32'h0000_0010, 32'hDEAD_BEEF);
      lookup("basic", 32'h0000_0010);
      check_eq("basic_const", bus.data, 32'hDEAD_BEEF);
      lookup("alias", 32'h0000_0410);
      check_eq("alias_hit0", {31'd0, bus.hit}, 32'd0);

      // Conflict: second write evicts the first.
      write(32'h0000_0020, 32'h1111_1111);
      write(32'h0000_0420, 32'h2222_2222);
      lookup("conf_new", 32'h0000_0420);
      check_eq("conf_const", bus.data, 32'h2222_2222);
      lookup("conf_old", 32'h0000_0020);
      check_eq("conf_old_hit0", {31'd0, bus.hit}, 32'd0);

      // Same-cycle read and write: old state before the edge, new after.
      @(negedge clk);
      bus.req_addr    = 32'h0000_0040;
      bus.write_addr  = 32'h0000_0040;
      bus.write_data  = 32'hCAFE_0001;
      bus.write_valid = 1'b1;
      written_q.push_back(32'h0000_0040);
      #1;
      check_now("same_pre");
      check_eq("same_pre_hit0", {31'd0, bus.hit}, 32'd0);
      @(negedge clk);
      bus.write_valid = 1'b0;
      #1;
      check_now("same_post");
      check_eq("same_post_const", bus.data, 32'hCAFE_0001);
      lookup("offs41", 32'h0000_0041);
      lookup("offs43", 32'h0000_0043);
      check_eq("offs43_const", bus.data, 32'hCAFE_0001);

      // Reset priority over a simultaneous write.
      write(32'h0000_0000, 32'hA000_0000);
      write(32'h0000_0004, 32'hA000_0004);
      write(32'h0000_03FC, 32'hA000_03FC);
      @(negedge clk);
      reset           = 1'b1;
      bus.write_addr  = 32'h0000_0008;
      bus.write_data  = $urandom;
      bus.write_valid = 1'b1;
      @(negedge clk);
      reset           = 1'b0;
      bus.write_valid = 1'b0;
      written_q.delete();
      lookup("rstp_0", 32'h0000_0000);
      check_eq("rstp_0_hit0", {31'd0, bus.hit}, 32'd0);
      lookup("rstp_4", 32'h0000_0004);
      lookup("rstp_3fc", 32'h0000_03FC);
      lookup("rstp_8", 32'h0000_0008);
      check_eq("rstp_8_hit0", {31'd0, bus.hit}, 32'd0);

      // Randomized refills and lookups with occasional resets.
      for (int n = 0; n < 600; n++) begin
         int unsigned op;
         op = $urandom_range(0, 99);
         if (op < 40) begin
            a = {$urandom_range(0, 7) == 0 ? $urandom : 32'($urandom_range(0, 3) << 10), 10'd0}
                | 32'($urandom_range(0, 255) << 2) | 32'($urandom_range(0, 3));
            write(a, $urandom);
         end else if (op < 97) begin
            if (written_q.size() > 0 && $urandom_range(0, 2) != 0)
               a = written_q[$urandom_range(0, written_q.size() - 1)] ^ 32'($urandom_range(0, 3));
            else
               a = $urandom;
            lookup("rand", a);
         end else begin
            do_reset();
            written_q.delete();
         end
      end

      // Idle refill port with random address/data: array must not change.
      for (int k = 0; k < 8; k++) write(32'($urandom_range(0, 255) << 2), $urandom);
      @(negedge clk);
      for (int n = 0; n < 100; n++) begin
         bus.write_addr  = $urandom;
         bus.write_data  = $urandom;
         bus.write_valid = 1'b0;
         @(negedge clk);
      end
      foreach (written_q[k]) lookup("idle", written_q[k]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
